knn_distance_topk: RTL
======================

# knn_distance_topk

Distance and classification stage of the KNN system, directly downstream of the memory controller. It takes one query vector, then streams in training samples (features plus label) over a valid/ready handshake. For each sample it accumulates the Manhattan distance to the query and keeps a sorted list of the K nearest. After the last sample it takes a majority vote over the kept labels and pulses `inference_done`, which the memory controller uses to begin its next write/read pass.

## Interface
- `W`, 8: feature width, unsigned.
- `N`, 4: features per vector.
- `K`, 3: neighbours kept; K ≥ 1.
- `L`, 2: label width; 2^L classes.
- `DW`, 10: distance width; must be ≥ W + ceil(log2 N).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: latch the query and begin inference.
- `query` in N*W: query vector; feature i is bits [i*W +: W].
- `train_valid` in 1: training beat valid.
- `train_ready` out 1: block can accept a beat.
- `train_feat` in N*W: training vector, same packing as `query`.
- `train_label` in L: class of the training sample.
- `train_last` in 1: this beat is the final sample.
- `busy` out 1: high in every state except IDLE and DONE.
- `result_valid` out 1: `result_class` and `nearest_dist` are valid.
- `result_class` out L: majority-vote class.
- `nearest_dist` out DW: distance held in list entry 0.
- `inference_done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ACCUM, INSERT, VOTE, DONE.
- IDLE/DONE + `start`:
  - Latch `query`.
  - Invalidate all K list entries and set their distances to all-ones.
  - Clear `result_valid`.
  - Go to LOAD.
- `start` in any other state is ignored.
- LOAD:
  - `train_ready` = 1; it is low in every other state.
  - On `train_valid && train_ready`, latch feat, label and last; clear the accumulator and feature counter; go to ACCUM.
- ACCUM: N cycles, one feature per cycle.
  - acc += |q_i − t_i|, unsigned absolute difference, zero-extended to DW.
  - No overflow is possible given the DW constraint.
- INSERT: one cycle.
  - The new entry takes position p = first index where the entry is invalid or new_dist < entry_dist (strict).
  - Entries p..K−2 shift down one position; entry K−1 is dropped.
  - If no such p exists, the list is unchanged.
  - Equal distances: an earlier sample stays ahead.
  - Next state: VOTE if the latched last flag is set, else LOAD.
- VOTE: 2^L cycles, class c = 0..2^L−1 in order.
  - count(c) = number of valid entries with label c.
  - Update best when count(c) > best_count (strict), so ties resolve to the lower class index.
- DONE:
  - `result_class` = best; `nearest_dist` = entry 0 distance.
  - `result_valid` = 1, held until the next `start` or `rst`.
  - `inference_done` = 1 for exactly the DONE-entry cycle.
- A LOAD beat with `train_last` = 1 is itself processed before the vote.
- A zero-sample inference is impossible; `train_last` terminates the stream.
- Reset values:
  - state IDLE; `train_ready`, `busy`, `result_valid`, `inference_done` all 0.
  - `result_class` 0; `nearest_dist` 0; list invalidated.
- `rst` mid-operation returns to IDLE immediately. The partial list is discarded and no `inference_done` is issued.

## Timing
- `start` at cycle s: LOAD at s+1, with `train_ready` high at s+1.
- Beat accepted at cycle t:
  - ACCUM t+1..t+N.
  - INSERT t+N+1.
  - LOAD (`train_ready` high again) at t+N+2.
- Sample throughput: one per N+2 cycles.
- Last beat accepted at t:
  - VOTE t+N+2 .. t+N+1+2^L.
  - DONE/`inference_done` at t+N+2+2^L; with the defaults this is t+10.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Nearest ordering and vote:
  - Stimulus (W=8, N=4, K=3, L=2): query {10,20,30,40}; samples {10,20,30,40}/L1, {0,0,0,0}/L2, {12,18,30,40}/L1, {11,20,30,40}/L3 (last).
  - Required: list distances 0,1,4 with labels 1,3,1; `result_class`=1; `nearest_dist`=0.
- Ties:
  - Stimulus: four samples, all at distance 5, labels 2,0,3,1.
  - Required: kept labels 2,0,3; counts all 1; `result_class`=0.
- Fewer than K samples:
  - Stimulus: a single sample, label 3, distance 7, with `train_last`.
  - Required: `result_class`=3; `nearest_dist`=7; invalid entries are not counted.
- Width edge:
  - Stimulus: query all 0; sample all 255.
  - Required: `nearest_dist`=1020 with no wrap.
  - Stimulus: query all 255; sample all 0.
  - Required: also 1020.
- Handshake and latency:
  - Stimulus: `train_valid` held high for 3 samples.
  - Required: accepts exactly 6 cycles apart; `inference_done` is a single-cycle pulse 10 cycles after the last accept.
  - Required: `start` pulsed during ACCUM has no effect.
- Reset mid-ACCUM:
  - Required: next cycle state is IDLE; all outputs are at reset values; no `inference_done`.
  - Required: a fresh `start` afterwards yields a correct result.

Source files
------------

// File: rtl/knn_distance_topk.sv
// KNN distance/top-K stage: Manhattan distance per training sample,
// sorted K-nearest list, then majority vote over the kept labels.
module knn_distance_topk #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int K  = 3,
  parameter int L  = 2,
  parameter int DW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*W-1:0]  query,
  input  logic            train_valid,
  output logic            train_ready,
  input  logic [N*W-1:0]  train_feat,
  input  logic [L-1:0]    train_label,
  input  logic            train_last,
  output logic            busy,
  output logic            result_valid,
  output logic [L-1:0]    result_class,
  output logic [DW-1:0]   nearest_dist,
  output logic            inference_done
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ACCUM, INSERT, VOTE, DONE
  } state_t;

  state_t           state;
  logic [N*W-1:0]   q_reg;
  logic [N*W-1:0]   t_feat;
  logic [L-1:0]     t_label;
  logic             t_last;
  logic [DW-1:0]    acc;
  logic [NW-1:0]    fidx;
  logic [DW-1:0]    ent_dist  [K];
  logic [L-1:0]     ent_label [K];
  logic [K-1:0]     ent_valid;
  logic [L-1:0]     vcls;
  logic [L-1:0]     best;
  logic [L-1:0]     best_n;
  logic [CW-1:0]    best_cnt;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     qf;
  logic [W-1:0]     tf;
  logic [W-1:0]     diff;
  logic [PW-1:0]    ins_pos;
  logic             ins_hit;

  assign qf   = q_reg[int'(fidx)*W +: W];
  assign tf   = t_feat[int'(fidx)*W +: W];
  assign diff = (qf > tf) ? qf - tf : tf - qf;

  // Scan from the tail so the lowest qualifying index wins.
  always_comb begin
    ins_hit = 1'b0;
    ins_pos = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (!ent_valid[i] || acc < ent_dist[i]) begin
        ins_hit = 1'b1;
        ins_pos = PW'(i);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < K; i++) begin
      if (ent_valid[i] && ent_label[i] == vcls)
        cnt = cnt + CW'(1);
    end
  end

  assign best_n = (cnt > best_cnt) ? vcls : best;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      train_ready    <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_class   <= '0;
      nearest_dist   <= '0;
      inference_done <= 1'b0;
      q_reg          <= '0;
      t_feat         <= '0;
      t_label        <= '0;
      t_last         <= 1'b0;
      acc            <= '0;
      fidx           <= '0;
      ent_valid      <= '0;
      vcls           <= '0;
      best           <= '0;
      best_cnt       <= '0;
      for (int i = 0; i < K; i++) begin
        ent_dist[i]  <= '1;
        ent_label[i] <= '0;
      end
    end else begin
      inference_done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            q_reg        <= query;
            ent_valid    <= '0;
            result_valid <= 1'b0;
            train_ready  <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
            for (int i = 0; i < K; i++)
              ent_dist[i] <= '1;
          end
        end
        LOAD: begin
          if (train_valid) begin
            t_feat      <= train_feat;
            t_label     <= train_label;
            t_last      <= train_last;
            acc         <= '0;
            fidx        <= '0;
            train_ready <= 1'b0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          acc  <= acc + DW'(diff);
          fidx <= fidx + NW'(1);
          if (fidx == NW'(N - 1))
            state <= INSERT;
        end
        INSERT: begin
          for (int i = K - 1; i > 0; i--) begin
            if (ins_hit && PW'(i) > ins_pos) begin
              ent_dist[i]  <= ent_dist[i-1];
              ent_label[i] <= ent_label[i-1];
              ent_valid[i] <= ent_valid[i-1];
            end
          end
          if (ins_hit) begin
            ent_dist[ins_pos]  <= acc;
            ent_label[ins_pos] <= t_label;
            ent_valid[ins_pos] <= 1'b1;
          end
          if (t_last) begin
            vcls     <= '0;
            best     <= '0;
            best_cnt <= '0;
            state    <= VOTE;
          end else begin
            train_ready <= 1'b1;
            state       <= LOAD;
          end
        end
        VOTE: begin
          if (cnt > best_cnt) begin
            best     <= vcls;
            best_cnt <= cnt;
          end
          if (vcls == '1) begin
            result_class   <= best_n;
            nearest_dist   <= ent_dist[0];
            result_valid   <= 1'b1;
            inference_done <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end else begin
            vcls <= vcls + L'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
